fifo_read_streamer: RTL and testbench

//   Read-side consumer of the async FIFO, in the Rclk domain. Pops words through the

---
 rtl/fifo_read_streamer.sv | 74 +++++++
 tb/tb_fifo_read_streamer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_streamer.sv
// Read-side consumer of the async FIFO: pops words on Rclk and presents them on a
// valid/ready stream through a 2-entry skid buffer, with a level-sensitive flush.
module fifo_read_streamer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  Rclk,
  input  logic                  Rrst,
  input  logic                  Rempty,
  input  logic [DATA_WIDTH-1:0] Rdata,
  output logic                  Rinc,
  input  logic                  Flush,
  output logic [DATA_WIDTH-1:0] M_data,
  output logic                  M_valid,
  input  logic                  M_ready,
  output logic [1:0]            Occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  r_occ;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  w_push;
  logic                  w_pop;

  // Pop decision uses only registered occupancy, so M_ready never reaches Rinc.
  assign Rinc      = Rrst & ~Rempty & (Flush | (r_occ != TWO));
  assign M_valid   = (r_occ != EMPTY) & ~Flush;
  assign w_push    = Rinc & ~Flush;
  assign w_pop     = M_valid & M_ready;
  assign M_data    = r_head;
  assign Occupancy = r_occ;

  always_ff @(posedge Rclk or negedge Rrst) begin
    if (!Rrst) begin
      r_occ  <= EMPTY;
      r_head <= '0;
      r_skid <= '0;
    end else if (Flush) begin
      r_occ <= EMPTY;
    end else begin
      case (r_occ)
        EMPTY: begin
          if (w_push) begin
            r_head <= Rdata;
            r_occ  <= ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_head <= Rdata;
          end else if (w_push) begin
            r_skid <= Rdata;
            r_occ  <= TWO;
          end else if (w_pop) begin
            r_occ <= EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            r_head <= r_skid;
            r_occ  <= ONE;
          end
        end
        default: r_occ <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Self-checking bench for fifo_read_streamer: behavioural FIFO on the read port and a
// scoreboard of popped words matched against accepted output beats.
module tb_fifo_read_streamer;

  localparam int W = 8;

  logic         Rclk = 1'b0;
  logic         Rrst = 1'b0;
  logic         Rempty = 1'b1;
  logic [W-1:0] Rdata = '0;
  logic         Rinc;
  logic         Flush = 1'b0;
  logic [W-1:0] M_data;
  logic         M_valid;
  logic         M_ready = 1'b0;
  logic [1:0]   Occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  int rinc_cnt = 0;
  bit gate_empty = 1'b0;

  logic         s_rinc, s_valid;
  logic [W-1:0] s_data;
  logic [1:0]   s_occ;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W:0]   want_q[$];

  fifo_read_streamer #(.DATA_WIDTH(W)) dut (
    .Rclk      (Rclk),
    .Rrst      (Rrst),
    .Rempty    (Rempty),
    .Rdata     (Rdata),
    .Rinc      (Rinc),
    .Flush     (Flush),
    .M_data    (M_data),
    .M_valid   (M_valid),
    .M_ready   (M_ready),
    .Occupancy (Occupancy)
  );

  always #5 Rclk = ~Rclk;

  task automatic refresh();
    Rempty = gate_empty || (fifo_q.size() == 0);
    Rdata  = Rempty ? W'($urandom) : fifo_q[0];
  endtask

  task automatic load(input logic [W-1:0] first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(first + W'(i));
    refresh();
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    want_q.delete();
    rinc_cnt = 0;
  endtask

  // One clock cycle: observe mid-cycle, then update the FIFO model just after the edge.
  task automatic tick();
    bit pop_now;
    @(negedge Rclk);
    s_rinc  = Rinc;
    s_valid = M_valid;
    s_data  = M_data;
    s_occ   = Occupancy;
    pop_now = Rinc;
    if (Rinc) rinc_cnt++;
    if (M_valid && M_ready) begin
      got_q.push_back(M_data);
      if (exp_q.size() > 0) want_q.push_back({1'b0, exp_q.pop_front()});
      else                  want_q.push_back({1'b1, {W{1'b0}}});
    end
    if (Flush || !Rrst) exp_q.delete();
    if (Rinc && !Flush) exp_q.push_back(Rdata);
    @(posedge Rclk);
    #1;
    if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
  endtask

  task automatic test_reset();
    load(8'h5A, 1);
    M_ready = 1'b1;
    #2;
    n_checks++; if (Rinc !== 1'b0)      begin n_fail++; $display("FAIL reset_rinc got=%b exp=0", Rinc); end
    n_checks++; if (M_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got=%b exp=0", M_valid); end
    n_checks++; if (M_data !== 8'h00)   begin n_fail++; $display("FAIL reset_data got=%h exp=00", M_data); end
    n_checks++; if (Occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", Occupancy); end
    rinc_cnt = 0;
    repeat (3) tick();
    n_checks++; if (rinc_cnt != 0) begin n_fail++; $display("FAIL reset_no_pop got=%0d exp=0", rinc_cnt); end
    fifo_q.delete();
    refresh();
    Rrst = 1'b1;
    tick();
    n_checks++; if (s_occ !== 2'd0 || s_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release occ=%0d valid=%b exp=0/0", s_occ, s_valid);
    end
  endtask

  task automatic test_single();
    clear_sb();
    M_ready = 1'b1;
    load(8'hA5, 1);
    tick();
    n_checks++; if (s_rinc !== 1'b1 || s_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_pop rinc=%b valid=%b exp=1/0", s_rinc, s_valid);
    end
    tick();
    n_checks++; if (s_valid !== 1'b1 || s_data !== 8'hA5 || s_rinc !== 1'b0) begin
      n_fail++; $display("FAIL single_out valid=%b data=%h rinc=%b exp=1/a5/0", s_valid, s_data, s_rinc);
    end
    tick();
    n_checks++; if (s_valid !== 1'b0 || s_occ !== 2'd0) begin
      n_fail++; $display("FAIL single_idle valid=%b occ=%0d exp=0/0", s_valid, s_occ);
    end
    n_checks++; if (rinc_cnt != 1 || got_q.size() != 1) begin
      n_fail++; $display("FAIL single_count pops=%0d beats=%0d exp=1/1", rinc_cnt, got_q.size());
    end
  endtask

  task automatic test_stream();
    clear_sb();
    M_ready = 1'b1;
    load(8'h00, 8);
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++; if (s_rinc !== (k < 8)) begin
        n_fail++; $display("FAIL stream_rinc cyc=%0d got=%b exp=%b", k, s_rinc, (k < 8));
      end
      n_checks++; if (s_valid !== (k >= 1 && k <= 8)) begin
        n_fail++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", k, s_valid, (k >= 1 && k <= 8));
      end
      if (k >= 1 && k <= 8) begin
        n_checks++; if (s_data !== W'(k - 1)) begin
          n_fail++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", k, s_data, W'(k - 1));
        end
      end
    end
    foreach (got_q[i]) begin
      n_checks++; if (want_q[i] !== {1'b0, got_q[i]}) begin
        n_fail++; $display("FAIL stream_sb idx=%0d got=%h exp=%h", i, got_q[i], want_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int t;
    clear_sb();
    M_ready = 1'b0;
    load(8'h10, 6);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k >= 1) begin
        n_checks++; if (s_valid !== 1'b1 || s_data !== 8'h10) begin
          n_fail++; $display("FAIL bp_hold cyc=%0d valid=%b data=%h exp=1/10", k, s_valid, s_data);
        end
      end
    end
    n_checks++; if (rinc_cnt != 2 || s_occ !== 2'd2 || s_rinc !== 1'b0) begin
      n_fail++; $display("FAIL bp_full pops=%0d occ=%0d rinc=%b exp=2/2/0", rinc_cnt, s_occ, s_rinc);
    end
    M_ready = 1'b1;
    t = 0;
    while (got_q.size() < 6 && t < 20) begin
      tick();
      t++;
    end
    n_checks++; if (got_q.size() != 6 || t != 6) begin
      n_fail++; $display("FAIL bp_drain beats=%0d cycles=%0d exp=6/6", got_q.size(), t);
    end
    foreach (got_q[i]) begin
      n_checks++; if (got_q[i] !== 8'h10 + W'(i) || want_q[i] !== {1'b0, got_q[i]}) begin
        n_fail++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got_q[i], 8'h10 + W'(i));
      end
    end
  endtask

  task automatic test_flush();
    int t;
    clear_sb();
    M_ready = 1'b0;
    load(8'h20, 5);
    repeat (3) tick();
    n_checks++; if (s_occ !== 2'd2 || s_data !== 8'h20) begin
      n_fail++; $display("FAIL flush_pre occ=%0d data=%h exp=2/20", s_occ, s_data);
    end
    Flush   = 1'b1;
    M_ready = 1'b1;
    #1;
    n_checks++; if (M_valid !== 1'b0 || Rinc !== 1'b1) begin
      n_fail++; $display("FAIL flush_mask valid=%b rinc=%b exp=0/1", M_valid, Rinc);
    end
    rinc_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (s_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_valid cyc=%0d got=%b exp=0", k, s_valid);
      end
    end
    Flush = 1'b0;
    #1;
    n_checks++; if (rinc_cnt != 3 || Occupancy !== 2'd0 || got_q.size() != 0) begin
      n_fail++; $display("FAIL flush_drain pops=%0d occ=%0d beats=%0d exp=3/0/0", rinc_cnt, Occupancy, got_q.size());
    end
    load(8'h30, 1);
    t = 0;
    while (got_q.size() < 1 && t < 10) begin
      tick();
      t++;
    end
    n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'h30 || want_q[0] !== 9'h030) begin
      n_fail++; $display("FAIL flush_resume beats=%0d first=%h exp=1/30", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int n_left;
    logic [W-1:0] head;
    logic [W-1:0] last;
    clear_sb();
    M_ready = 1'b1;
    load(8'h40, 12);
    repeat (4) tick();
    Rrst = 1'b0;
    #1;
    n_checks++; if (M_valid !== 1'b0 || M_data !== 8'h00 || Occupancy !== 2'd0 || Rinc !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async valid=%b data=%h occ=%0d rinc=%b exp=0/00/0/0", M_valid, M_data, Occupancy, Rinc);
    end
    head = fifo_q[0];
    last = got_q[$];
    rinc_cnt = 0;
    repeat (2) tick();
    n_checks++; if (rinc_cnt != 0) begin
      n_fail++; $display("FAIL rmid_no_pop got=%0d exp=0", rinc_cnt);
    end
    got_q.delete();
    want_q.delete();
    Rrst = 1'b1;
    n_left = fifo_q.size();
    t = 0;
    while (got_q.size() < n_left && t < 40) begin
      tick();
      t++;
    end
    n_checks++; if (got_q.size() != n_left || n_left != 32'h4C - int'(head)) begin
      n_fail++; $display("FAIL rmid_count beats=%0d exp=%0d", got_q.size(), 32'h4C - int'(head));
    end
    n_checks++; if (got_q.size() > 0 && got_q[0] <= last) begin
      n_fail++; $display("FAIL rmid_dup first=%h last_before=%h", got_q[0], last);
    end
    foreach (got_q[i]) begin
      n_checks++; if (got_q[i] !== head + W'(i) || want_q[i] !== {1'b0, got_q[i]}) begin
        n_fail++; $display("FAIL rmid_order idx=%0d got=%h exp=%h", i, got_q[i], head + W'(i));
      end
    end
  endtask

  task automatic test_rempty_toggle();
    int t;
    logic [W-1:0] held;
    bit stalled;
    clear_sb();
    load(8'h50, 8);
    t = 0;
    stalled = 1'b0;
    held = '0;
    while (got_q.size() < 8 && t < 80) begin
      gate_empty = ~gate_empty;
      M_ready = 1'($urandom_range(0, 1));
      refresh();
      tick();
      if (stalled) begin
        n_checks++; if (s_valid !== 1'b1 || s_data !== held) begin
          n_fail++; $display("FAIL toggle_stable cyc=%0d valid=%b data=%h exp=1/%h", t, s_valid, s_data, held);
        end
      end
      stalled = s_valid && !M_ready;
      held = s_data;
      t++;
    end
    gate_empty = 1'b0;
    refresh();
    n_checks++; if (got_q.size() != 8) begin
      n_fail++; $display("FAIL toggle_count beats=%0d exp=8", got_q.size());
    end
    foreach (got_q[i]) begin
      n_checks++; if (got_q[i] !== 8'h50 + W'(i) || want_q[i] !== {1'b0, got_q[i]}) begin
        n_fail++; $display("FAIL toggle_order idx=%0d got=%h exp=%h", i, got_q[i], 8'h50 + W'(i));
      end
    end
    n_checks++; if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL toggle_leftover got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_rempty_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
